// File: rtl/digit_serial_pkg.sv
// Shared types and elaboration helpers for the digit-serial add/subtract unit.
package digit_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of digit cycles needed to cover the full operand width.
  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // Width of the digit index register; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_adder_cell.sv
// Combinational DIGIT-bit ripple adder built from full-adder slices.
// c_top is the carry into the most significant slice, used by the caller
// to form signed overflow on the last digit.
module digit_adder_cell #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_top
);

  // Ripple the carry through each bit slice, remembering the carry into the top slice.
  always_comb begin
    logic c;
    c     = cin;
    c_top = cin;
    sum   = '0;
    for (int i = 0; i < DIGIT; i++) begin
      c_top  = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    cout = c;
  end

endmodule

// File: rtl/digit_serial_addsub.sv
// Multi-cycle add/subtract unit processing DIGIT bits per clock.
// Optional build macro DIGIT_SERIAL_ADDSUB_SATURATE_EN clamps the result to
// the signed limit on overflow; by default the result wraps.
module digit_serial_addsub
  import digit_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [WIDTH-1:0] POS_LIMIT = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_LIMIT = {1'b1, {(WIDTH-1){1'b0}}};

  if ((WIDTH % DIGIT) != 0) begin : g_width_check
    $error("digit_serial_addsub: WIDTH must be a multiple of DIGIT");
  end
  if ((DIGIT < 1) || (DIGIT > WIDTH)) begin : g_digit_check
    $error("digit_serial_addsub: DIGIT must lie in 1..WIDTH");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;       // latched operand A
  logic [WIDTH-1:0] b_q, b_d;       // latched effective B (inverted for subtract)
  logic [WIDTH-1:0] acc_q, acc_d;   // partial result, hidden from the output
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             cy_q, cy_d;     // inter-digit carry
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] dig_a, dig_b, dig_s;
  logic             dig_cout, dig_ctop;

  assign dig_a = a_q[idx_q*DIGIT +: DIGIT];
  assign dig_b = b_q[idx_q*DIGIT +: DIGIT];

  digit_adder_cell #(
    .DIGIT (DIGIT)
  ) u_cell (
    .a     (dig_a),
    .b     (dig_b),
    .cin   (cy_q),
    .sum   (dig_s),
    .cout  (dig_cout),
    .c_top (dig_ctop)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          cy_d    = sub;
          idx_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d[idx_q*DIGIT +: DIGIT] = dig_s;
        cy_d  = dig_cout;
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
          carry_d = dig_cout;
          ovf_d   = dig_cout ^ dig_ctop;
`ifdef DIGIT_SERIAL_ADDSUB_SATURATE_EN
          // On overflow both operands share a sign, so A's sign gives the direction.
          if (dig_cout ^ dig_ctop) begin
            sum_d = a_q[WIDTH-1] ? NEG_LIMIT : POS_LIMIT;
          end else begin
            sum_d = acc_d;
          end
`else
          sum_d = acc_d;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d != RUN);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  // State, operand and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

  // POS_LIMIT/NEG_LIMIT are only referenced by the saturating build.
  logic unused_limits;
  assign unused_limits = ^{POS_LIMIT, NEG_LIMIT};

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed and randomized bench for digit_serial_addsub (DIGIT=2 and DIGIT=8).
module tb_digit_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start2, start8, sub;
  logic [W-1:0] a, b;
  logic         ready2, busy2, done2, carry2, ovf2;
  logic         ready8, busy8, done8, carry8, ovf8;
  logic [W-1:0] sum2, sum8;
  logic         sel8;

  logic         o_ready, o_busy, o_done, o_carry, o_ovf;
  logic [W-1:0] o_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digit_serial_addsub #(.WIDTH(W), .DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub), .a(a), .b(b),
    .ready(ready2), .busy(busy2), .done(done2), .sum(sum2),
    .carry(carry2), .overflow(ovf2)
  );

  digit_serial_addsub #(.WIDTH(W), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub), .a(a), .b(b),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8),
    .carry(carry8), .overflow(ovf8)
  );

  assign o_ready = sel8 ? ready8 : ready2;
  assign o_busy  = sel8 ? busy8  : busy2;
  assign o_done  = sel8 ? done8  : done2;
  assign o_sum   = sel8 ? sum8   : sum2;
  assign o_carry = sel8 ? carry8 : carry2;
  assign o_ovf   = sel8 ? ovf8   : ovf2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                       output logic [W-1:0] esum, output logic ecy, output logic eov);
    int sa, sb, r, ua, ub;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (ms) begin
      r    = sa - sb;
      esum = W'(ua - ub);
      ecy  = (ua >= ub);
    end else begin
      r    = sa + sb;
      esum = W'(ua + ub);
      ecy  = ((ua + ub) > 255);
    end
    eov = (r > 127) || (r < -128);
`ifdef DIGIT_SERIAL_ADDSUB_SATURATE_EN
    if (eov) esum = (r > 0) ? 8'h7F : 8'h80;
`endif
  endtask

  // Drive a start for one cycle; caller sits just after an active edge.
  task automatic issue(input logic use8, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic is);
    sel8 = use8;
    a    = ia;
    b    = ib;
    sub  = is;
    if (use8) start8 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    start8 = 1'b0;
    a   = W'($urandom);
    b   = W'($urandom);
    sub = 1'($urandom);
  endtask

  // Wait (bounded) for done and compare latency and results with the model.
  task automatic wait_done(input string tag, input int n0, input int exp_n,
                           input logic [W-1:0] ea, input logic [W-1:0] eb, input logic es);
    int n;
    logic [W-1:0] esum;
    logic ecy, eov;
    n = n0;
    while (!o_done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    model(ea, eb, es, esum, ecy, eov);
    chk({tag, "_latency"}, n, exp_n);
    chk({tag, "_sum"}, o_sum, esum);
    chk({tag, "_carry"}, o_carry, ecy);
    chk({tag, "_ovf"}, o_ovf, eov);
    chk({tag, "_ready"}, o_ready, 1);
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, o_done, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb, held;
    logic rs, r8, seen_done;
    rst_n = 1'b0; start2 = 1'b0; start8 = 1'b0; sub = 1'b0;
    a = '0; b = '0; sel8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready2, 1);
    chk("rst_busy", busy2, 0);
    chk("rst_done", done2, 0);
    chk("rst_sum", sum2, 0);
    chk("rst_flags", {carry2, ovf2}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic additions, including signed overflow.
    issue(0, 8'd100, 8'd27, 0);
    chk("tp1_busy", o_busy, 1);
    chk("tp1_ready_low", o_ready, 0);
    wait_done("tp1", 0, 4, 8'd100, 8'd27, 0);
    chk("tp1_sum_const", o_sum, 127);
    idle_cycle("tp1");
    issue(0, 8'd200, 8'd100, 0);
    wait_done("tp2", 0, 4, 8'd200, 8'd100, 0);
    chk("tp2_sum_const", o_sum, 8'h2C);
    idle_cycle("tp2");
    issue(0, 8'd127, 8'd1, 0);
    wait_done("tp3", 0, 4, 8'd127, 8'd1, 0);
`ifdef DIGIT_SERIAL_ADDSUB_SATURATE_EN
    chk("tp3_sum_const", o_sum, 8'h7F);
`else
    chk("tp3_sum_const", o_sum, 8'h80);
`endif
    chk("tp3_ovf_const", o_ovf, 1);
    idle_cycle("tp3");

    // Asynchronous reset at digit index 2 aborts without a done pulse.
    issue(0, 8'h12, 8'h34, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstrun_ready", o_ready, 1);
    chk("rstrun_busy", o_busy, 0);
    chk("rstrun_sum", o_sum, 0);
    chk("rstrun_flags", {o_carry, o_ovf, o_done}, 0);
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen_done |= o_done;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      seen_done |= o_done;
    end
    chk("rstrun_no_done", seen_done, 0);

    // Subtract with borrow, then back-to-back start on the done cycle.
    issue(0, 8'd5, 8'd7, 1);
    wait_done("tp4a", 0, 4, 8'd5, 8'd7, 1);
    chk("tp4a_sum_const", o_sum, 8'hFE);
    issue(0, 8'd7, 8'd5, 1);
    chk("tp4b_busy", o_busy, 1);
    chk("tp4b_done_low", o_done, 0);
    chk("tp4b_sum_held", o_sum, 8'hFE);
    wait_done("tp4b", 0, 4, 8'd7, 8'd5, 1);
    chk("tp4b_sum_const", o_sum, 8'h02);
    idle_cycle("tp4b");

    // start pulsed mid-RUN with other operands is ignored.
    issue(0, 8'h33, 8'h44, 0);
    held  = o_sum;
    start2 = 1'b1; a = 8'hFF; b = 8'hFF; sub = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk("ign_sum_hidden", o_sum, held);
    wait_done("ign", 1, 4, 8'h33, 8'h44, 0);
    idle_cycle("ign");

    // Single-digit configuration.
    issue(1, 8'hFF, 8'h01, 0);
    chk("d8_busy", o_busy, 1);
    wait_done("d8", 0, 1, 8'hFF, 8'h01, 0);
    chk("d8_sum_const", o_sum, 8'h00);
    chk("d8_carry_const", o_carry, 1);
    idle_cycle("d8");

    // Randomized operations on both configurations.
    for (int k = 0; k < 40; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      r8 = 1'(k & 1);
      if (k % 10 == 0) begin
        ra = 8'h80;
        rb = (k % 20 == 0) ? 8'h01 : 8'h80;
      end
      issue(r8, ra, rb, rs);
      wait_done("rnd", 0, r8 ? 1 : 4, ra, rb, rs);
      idle_cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
